// File: rtl/dm_responder.sv
// Data-memory responder for the MEM stage: word storage with programmable
// wait states, a one-cycle ack/err response and a stall toward the pipeline.
module dm_responder #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rstDM,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        stall
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? CNT_W'(0) : CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [31:0]         mem_q [DEPTH];

  logic                req_bad;
  logic                acc_en;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_idx;
  logic [31:0]         acc_wdata;

  // Misaligned or beyond the top of storage: answered as an error, no access.
  assign req_bad = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);

  // Next-state, storage access and response computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    acc_en    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          idx_d   = addr[ADDR_W+1:2];
          wdata_d = wdata;
          if (req_bad) begin
            state_d = S_RESP;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end else if (WAIT_CYCLES == 0) begin
            // Zero wait states: access straight from the live request.
            state_d   = S_RESP;
            ack_d     = 1'b1;
            acc_en    = 1'b1;
            acc_we    = we;
            acc_idx   = addr[ADDR_W+1:2];
            acc_wdata = wdata;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end

      S_WAIT: begin
        if (cnt_q != CNT_W'(0)) begin
          cnt_d = CNT_W'(cnt_q - CNT_W'(1));
        end else begin
          state_d = S_RESP;
          ack_d   = 1'b1;
          acc_en  = 1'b1;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Loads register the addressed word; stores leave rdata untouched.
    if (acc_en && !acc_we) begin
      rdata_d = mem_q[acc_idx];
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rstDM) begin
    if (!rstDM) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Word storage; not reset, a store commits only on its response edge.
  always_ff @(posedge clk) begin
    if (acc_en && acc_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign err   = err_q;
  assign stall = req & ~ack_q;

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, hand-written corner
// sequences and randomized traffic against a word-array reference model.
module tb_dm_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned WC     = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int          TMO    = 40;

  logic        clk = 1'b0;
  logic        rstDM;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        err;
  logic        stall;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];
  logic [31:0] m_rdata;

  dm_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WC)) dut (
    .clk   (clk),
    .rstDM (rstDM),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .ack   (ack),
    .err   (err),
    .stall (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: a plain word array plus the last value seen on rdata.
  task automatic model_apply(input bit w, input logic [31:0] a, input logic [31:0] d,
                             output bit e_err, output logic [31:0] e_rd, output int e_lat);
    int unsigned idx;
    if ((a % 4) != 0 || a >= 4 * DEPTH) begin
      e_err   = 1'b1;
      m_rdata = 32'd0;
      e_lat   = 1;
    end else begin
      idx   = a / 4;
      e_err = 1'b0;
      if (w) begin
        m_mem[idx] = d;
        m_wr[idx]  = 1'b1;
      end else begin
        m_rdata = m_mem[idx];
      end
      e_lat = WC + 1;
    end
    e_rd = m_rdata;
  endtask

  // One isolated transaction: issue at a falling edge, count edges to ack.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output int lat, output logic [31:0] rd, output logic e,
                     output bit stall_ok, output bit ack_one);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    #1;
    stall_ok = (stall === 1'b1);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (ack === 1'b1) break;
      if (stall !== 1'b1) stall_ok = 1'b0;
      if (lat >= TMO) break;
    end
    rd = rdata;
    e  = err;
    if (stall !== 1'b0) stall_ok = 1'b0;
    req = 1'b0; we = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'd0;
    @(posedge clk); #1;
    ack_one = (ack === 1'b0) && (err === 1'b0);
  endtask

  task automatic run_check(input string tag, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input bit e_err,
                           input logic [31:0] e_rd, input int e_lat);
    int          lat;
    logic [31:0] rd;
    logic        e;
    bit          s_ok;
    bit          a_one;
    txn(w, a, d, lat, rd, e, s_ok, a_one);
    chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
    chk({tag, "_err"}, 32'(e), 32'(e_err));
    chk({tag, "_rdata"}, rd, e_rd);
    chk({tag, "_stall"}, 32'(s_ok), 32'd1);
    chk({tag, "_ack_width"}, 32'(a_one), 32'd1);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    bit          e_err;
    logic [31:0] e_rd;
    int          e_lat;
  } vec_t;

  vec_t vecs [9];

  initial begin
    bit          me;
    logic [31:0] mrd;
    int          mlat;
    int          n;

    vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 3};
    vecs[1] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[2] = '{1'b1, 32'h0000_0013, 32'h0BAD_F00D, 1'b1, 32'h0000_0000, 1};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[4] = '{1'b1, 32'h0000_0FFC, 32'h0000_0001, 1'b0, 32'hDEAD_BEEF, 3};
    vecs[5] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 1'b0, 32'h0000_0001, 3};
    vecs[6] = '{1'b0, 32'h0000_1000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1};
    vecs[7] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 1'b1, 32'h0000_0000, 1};
    vecs[8] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 3};

    for (int i = 0; i < int'(DEPTH); i++) m_wr[i] = 1'b0;
    m_rdata = 32'd0;

    rstDM = 1'b0; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
    repeat (2) @(negedge clk);
    rstDM = 1'b1;

    // Asynchronous reset mid-cycle with req low.
    @(posedge clk); #3;
    rstDM = 1'b0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rstDM = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 9; i++) begin
      model_apply(vecs[i].w, vecs[i].a, vecs[i].d, me, mrd, mlat);
      run_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].a, vecs[i].d,
                vecs[i].e_err, vecs[i].e_rd, vecs[i].e_lat);
    end

    // Back-to-back with req held high: store then load 0x40.
    begin
      int gap;
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h40; wdata = 32'hA5A5_A5A5;
      n = 0;
      do begin
        @(posedge clk); #1; n++;
      end while (ack !== 1'b1 && n < TMO);
      chk("b2b_first_ack", 32'(ack), 32'd1);
      chk("b2b_first_err", 32'(err), 32'd0);
      we = 1'b0; wdata = 32'd0;
      gap = 0;
      do begin
        @(posedge clk); #1; gap++;
      end while (ack !== 1'b1 && gap < TMO);
      chk("b2b_gap", 32'(gap), 32'd4);
      chk("b2b_rdata", rdata, 32'hA5A5_A5A5);
      chk("b2b_err", 32'(err), 32'd0);
      req = 1'b0;
      @(posedge clk); #1;
      model_apply(1'b1, 32'h40, 32'hA5A5_A5A5, me, mrd, mlat);
      model_apply(1'b0, 32'h40, 32'd0, me, mrd, mlat);
    end

    // Reset during RESP removes ack at once.
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = 32'h10;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (ack !== 1'b1 && n < TMO);
    chk("resp_ack_seen", 32'(ack), 32'd1);
    chk("resp_rdata", rdata, 32'hDEAD_BEEF);
    #1;
    rstDM = 1'b0;
    req = 1'b0;
    #1;
    chk("resp_rst_ack", 32'(ack), 32'd0);
    chk("resp_rst_rdata", rdata, 32'd0);
    chk("resp_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rstDM = 1'b1;
    m_rdata = 32'd0;

    // Reset during WAIT discards the pending store.
    model_apply(1'b1, 32'h20, 32'h1111_1111, me, mrd, mlat);
    run_check("mid_setup", 1'b1, 32'h20, 32'h1111_1111, 1'b0, 32'd0, 3);
    model_apply(1'b0, 32'h10, 32'd0, me, mrd, mlat);
    run_check("mid_load10", 1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 3);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h2222_2222;
    @(posedge clk);
    @(posedge clk); #2;
    rstDM = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    req = 1'b0; we = 1'b0;
    @(negedge clk);
    rstDM = 1'b1;
    m_rdata = 32'd0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) n++;
    end
    chk("mid_no_ack", 32'(n), 32'd0);
    model_apply(1'b0, 32'h20, 32'd0, me, mrd, mlat);
    run_check("mid_load20", 1'b0, 32'h20, 32'd0, 1'b0, 32'h1111_1111, 3);

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      int unsigned r;
      int unsigned idx;
      logic [31:0] a;
      logic [31:0] d;
      bit          w;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 1) == 1) idx = $urandom_range(0, 15);
      else                           idx = $urandom_range(DEPTH - 4, DEPTH - 1);
      if (r < 10)      a = (32'(idx) << 2) | 32'($urandom_range(1, 3));
      else if (r < 18) a = (32'($urandom_range(1, 1000)) << 12) | (32'(idx) << 2);
      else             a = 32'(idx) << 2;
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      if (!w && (a % 4) == 0 && a < 4 * DEPTH && !m_wr[a / 4]) w = 1'b1;
      model_apply(w, a, d, me, mrd, mlat);
      run_check($sformatf("rnd%0d", t), w, a, d, me, mrd, mlat);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Memory-side responder for the MEM-stage data access. The pipeline issues load/store requests as initiator; this block holds the data storage, answers after a programmable number of wait states and raises a stall toward the pipeline.
- It replaces the zero-latency combinational data memory path so the core can be exercised against realistic, multi-cycle memory timing.

Parameters:
- ADDR_W, 10, number of word-address bits; storage depth is 2^ADDR_W 32-bit words; byte range is 0 to 2^(ADDR_W+2)-1.
- WAIT_CYCLES, 2, wait states inserted before the response; legal range 0..15; the counter is 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- rstDM  input  1  asynchronous, active-low reset.
- req  input  1  access request from the MEM stage; held high and stable until ack.
- we  input  1  1 = store, 0 = load; qualified by req.
- addr  input  32  byte address; must be word aligned.
- wdata  input  32  store data.
- rdata  output  32  load data; valid during the ack cycle.
- ack  output  1  one-cycle response strobe.
- err  output  1  error flag; valid during the ack cycle.
- stall  output  1  pipeline hold request.

Behaviour:
- Reset (rstDM=0, asynchronous): state=IDLE, counter=0, ack=0, err=0, rdata=0, all captured request registers cleared. Storage contents are not cleared; they are undefined until written.
- FSM states: IDLE, WAIT, RESP.
- IDLE, when req=1 at a rising edge:
  - Capture we, addr and wdata. Inputs are ignored from then on until ack.
  - Error case: addr[1:0]!=0, or addr[31:ADDR_W+2]!=0. Go to RESP with err pending; no storage access takes place.
  - Else, if WAIT_CYCLES==0, go directly to RESP.
  - Else go to WAIT with counter=WAIT_CYCLES-1.
- WAIT:
  - While counter!=0: decrement the counter and stay in WAIT.
  - When counter==0: go to RESP. On that same edge:
    - A store writes wdata into word addr[ADDR_W+1:2].
    - A load registers that word into rdata.
- RESP: ack=1 for exactly one cycle, then return to IDLE unconditionally.
  - err=1 only on an error response; err=0 otherwise.
  - On an error response rdata=0.
  - A successful store leaves rdata unchanged.
- ack and err are registered and are 0 in every state except RESP.
- Latency: ack is high in the cycle following the (WAIT_CYCLES+1)-th rising edge after the sampling edge, counting the sampling edge as the first. Error responses always take 1 edge.
- stall = req & ~ack (combinational). The pipeline freezes while stall=1 and advances on the ack cycle.
- Back-to-back: a request is accepted only in IDLE. The edge that ends RESP returns the FSM to IDLE; the next edge samples the new req. Minimum issue-to-issue spacing is therefore WAIT_CYCLES+2 cycles.
- Boundary cases:
  - If req drops before ack (protocol violation), the transaction still completes on the captured values.
  - A reset during WAIT discards the pending store; storage is untouched because the write commits only on the WAIT-to-RESP edge.
  - A reset during RESP kills ack immediately.
- Addresses wrap nowhere: the top address 2^(ADDR_W+2)-4 is legal, and the next word address is an error.

Test Plan:
- Reset: hold rstDM=0 mid-cycle with req=0 -> ack=0, err=0, rdata=0, stall=0 asynchronously, without waiting for a clock edge.
- Store/load (WAIT_CYCLES=2):
  - Store 0xDEADBEEF to 0x10 -> stall=1 for 3 cycles, then ack=1 and err=0 on the 4th cycle.
  - Load from 0x10 -> rdata=0xDEADBEEF in its ack cycle, 3 edges after sampling.
- Misaligned store: store 0x0BADF00D to 0x13 -> ack after 1 edge with err=1 and rdata=0. A following load from 0x10 still returns 0xDEADBEEF.
- Range (ADDR_W=10):
  - Load from 0xFFC after storing 0x00000001 there -> rdata=0x00000001, err=0.
  - Load from 0x1000 -> err=1 after 1 edge.
- Back-to-back with req held high: store 0xA5A5A5A5 to 0x40, then immediately load from 0x40 -> second ack exactly 4 cycles after the first, with rdata=0xA5A5A5A5.
- Reset mid-op:
  - Setup: store 0x11111111 to 0x20. Issue a store of 0x22222222 to 0x20 and pulse rstDM low while in WAIT.
  - Required: no ack for the interrupted store; a subsequent load from 0x20 returns 0x11111111.
